clk_reset_sequencer: RTL and testbench
======================================

# clk_reset_sequencer

Synthesizable, parametrised successor to the testbench clock/reset generator. Sits downstream of the single system clock. Produces per-channel divided clock-enables, divided toggle outputs and staged per-channel reset release for NUM_CH sub-domains. Supports a soft-reset handshake that re-runs the release sequence without a global reset.

## Interface
Parameters:
- NUM_CH, 4, number of output channels (1..16)
- CNT_W, 8, width of divider/phase fields per channel
- RESET_DELAY, 4, cycles all channels stay in reset after sequence start (>=1)
- STAGE_GAP, 2, cycles between successive channel releases (>=1)

Ports:
- CLK  in  1  single system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- DIV_RATIO  in  NUM_CH*CNT_W  per-channel divide ratio; channel i at bits [i*CNT_W +: CNT_W]
- PHASE  in  NUM_CH*CNT_W  per-channel initial counter value, same packing
- SOFT_RST_REQ  in  1  level request to re-run the reset sequence
- SOFT_RST_ACK  out  1  one-cycle pulse when a request is accepted
- CH_RST  out  NUM_CH  per-channel active-high reset
- CH_RSTN  out  NUM_CH  bitwise inverse of CH_RST
- CH_CE  out  NUM_CH  one-cycle clock-enable pulse at CLK/ratio
- CH_TOGGLE  out  NUM_CH  flips on every CH_CE; divided square wave at CLK/(2*ratio)
- ALL_READY  out  1  high when every channel is out of reset

## Operation
- FSM states: SEQ_HOLD, SEQ_STAGE, SEQ_RUN.
- SEQ_HOLD: all CH_RST=1. The cycle counter runs RESET_DELAY cycles, then the FSM enters SEQ_STAGE.
- SEQ_STAGE: releases channel 0 on entry. Releases channel i+1 STAGE_GAP cycles after channel i, in ascending order. Enters SEQ_RUN on the same edge channel NUM_CH-1 is released.
- SEQ_RUN: ALL_READY=1. SOFT_RST_REQ=1 gives SOFT_RST_ACK=1 for one cycle, all CH_RST reassert on the same edge, and the FSM goes to SEQ_HOLD.
- SOFT_RST_REQ in SEQ_HOLD or SEQ_STAGE: ignored, no ACK. The requester holds REQ until it sees ACK. A REQ still high after ACK is not accepted again until SEQ_RUN is re-reached.
- Divider, per channel:
  - The release edge loads DIV_RATIO and PHASE into channel registers. Inputs are ignored at all other times.
  - Ratio 0 is treated as 1.
  - PHASE >= ratio is clamped to ratio-1.
  - The counter increments each cycle and wraps from ratio-1 to 0.
  - CH_CE_i = released_i AND (cnt_i == ratio_i-1). It is decoded from registers only, with no input-to-output combinational path.
- Ratio 1: CH_CE stays high continuously while the channel is released.
- Reassertion of CH_RST (RST or soft reset) clears the counter, CH_CE and CH_TOGGLE on the same edge.

## Timing
- Reset values while RST=1: CH_RST all 1, CH_RSTN all 0, CH_CE 0, CH_TOGGLE 0, SOFT_RST_ACK 0, ALL_READY 0, FSM SEQ_HOLD, counters 0.
- Let edge 0 be the first rising edge with RST=0.
  - CH_RST[i] falls after edge RESET_DELAY + i*STAGE_GAP.
  - ALL_READY rises after edge RESET_DELAY + (NUM_CH-1)*STAGE_GAP.
- First CH_CE_i occurs (ratio-1-phase) cycles after channel i's first released cycle. Phase = ratio-1 gives CE in the first released cycle.
- Soft reset: ACK high in cycle k. CH_RST all 1 and ALL_READY 0 from cycle k+1. Release timing then repeats with edge k as edge 0.
- RST asserted mid-sequence or mid-handshake: returns to reset values on the next edge. Any pending ACK is dropped.

## Configuration
- CLK_RESET_SEQ_SOFT_RST_EN defined: soft-reset handshake as above.
- CLK_RESET_SEQ_SOFT_RST_EN undefined:
  - SOFT_RST_REQ unused; SOFT_RST_ACK tied 0.
  - SEQ_RUN is terminal until RST.
  - Ports are unchanged.

## Structure
- clk_reset_seq_pkg holds:
  - typedef enum seq_state_t {SEQ_HOLD, SEQ_STAGE, SEQ_RUN}
  - localparam function for sequencer counter width: clog2 of max(RESET_DELAY, STAGE_GAP)+1
- Sub-module clk_ce_divider, one per channel via generate. Ports: CLK, RST, LOAD, RELEASED, RATIO, PHASE, CE, TOGGLE.
- The top holds the FSM, stage counter, channel index and handshake.

## Test plan
- Defaults, all DIV_RATIO=1, PHASE=0, RST high 5 cycles then low:
  - CH_RST[0..3] fall after edges 4, 6, 8, 10; ALL_READY rises after edge 10.
  - CH_CE[i] is high every cycle after its release.
- Ch1 with DIV_RATIO=4, PHASE=0: CH_CE[1] pulses every 4th cycle, first pulse 3 cycles after release; CH_TOGGLE[1] has period 8.
- Ch2 with DIV_RATIO=5, PHASE=9 (clamped to 4): CH_CE[2] in the first released cycle, then every 5 cycles.
- DIV_RATIO=0 on ch3: same behaviour as ratio 1.
- In SEQ_RUN, SOFT_RST_REQ held high:
  - ACK pulses once; all CH_RST high next cycle; counters and toggles clear.
  - Staged release repeats with identical offsets; no second ACK while REQ stays high through SEQ_HOLD and SEQ_STAGE.
- RST asserted during SEQ_STAGE after ch1 is released: all outputs return to reset values on the next edge, and the sequence restarts cleanly when RST drops.

Source files
------------

// File: rtl/clk_reset_seq_pkg.sv
// rtl/clk_reset_seq_pkg.sv - shared types and width helper for the clock/reset sequencer
package clk_reset_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_HOLD  = 2'd0,
        SEQ_STAGE = 2'd1,
        SEQ_RUN   = 2'd2
    } seq_state_t;

    // Width of the shared hold/stage counter: must hold values up to max(RESET_DELAY, STAGE_GAP)
    function automatic int seq_cnt_w(input int reset_delay, input int stage_gap);
        int m;
        m = (reset_delay > stage_gap) ? reset_delay : stage_gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_ce_divider.sv
// rtl/clk_ce_divider.sv - per-channel clock-enable divider with phase preload and toggle output
module clk_ce_divider
    import clk_reset_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic             RELEASED,
    input  logic [CNT_W-1:0] RATIO,
    input  logic [CNT_W-1:0] PHASE,
    output logic             CE,
    output logic             TOGGLE
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] ratio_eff;
    logic [CNT_W-1:0] phase_eff;
    logic [CNT_W-1:0] ratio_q;
    logic [CNT_W-1:0] cnt_q;
    logic             toggle_q;
    logic             wrap;

    // Sanitise the load values: ratio 0 behaves as 1, phase is clamped into [0, ratio-1]
    always_comb begin
        ratio_eff = (RATIO == '0) ? ONE : RATIO;
        phase_eff = (PHASE >= ratio_eff) ? (ratio_eff - ONE) : PHASE;
    end

    assign wrap   = (cnt_q == (ratio_q - ONE));
    assign CE     = RELEASED && wrap;
    assign TOGGLE = toggle_q;

    // Capture settings on the release edge, then count and toggle while released
    always_ff @(posedge CLK) begin
        if (RST) begin
            ratio_q  <= ONE;
            cnt_q    <= '0;
            toggle_q <= 1'b0;
        end else if (LOAD) begin
            ratio_q <= ratio_eff;
            cnt_q   <= phase_eff;
        end else if (RELEASED) begin
            cnt_q    <= wrap ? '0 : (cnt_q + ONE);
            toggle_q <= toggle_q ^ wrap;
        end
    end

endmodule

// File: rtl/clk_reset_sequencer.sv
// rtl/clk_reset_sequencer.sv - staged per-channel reset release with clock-enable dividers; soft reset when CLK_RESET_SEQ_SOFT_RST_EN is defined
module clk_reset_sequencer
    import clk_reset_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int RESET_DELAY = 4,
    parameter int STAGE_GAP   = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_CH*CNT_W-1:0] DIV_RATIO,
    input  logic [NUM_CH*CNT_W-1:0] PHASE,
    input  logic                    SOFT_RST_REQ,
    output logic                    SOFT_RST_ACK,
    output logic [NUM_CH-1:0]       CH_RST,
    output logic [NUM_CH-1:0]       CH_RSTN,
    output logic [NUM_CH-1:0]       CH_CE,
    output logic [NUM_CH-1:0]       CH_TOGGLE,
    output logic                    ALL_READY
);

    localparam int SEQ_CNT_W = seq_cnt_w(RESET_DELAY, STAGE_GAP);
    localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [SEQ_CNT_W-1:0] HOLD_LAST  = SEQ_CNT_W'(RESET_DELAY);
    localparam logic [SEQ_CNT_W-1:0] STAGE_LAST = SEQ_CNT_W'(STAGE_GAP - 1);
    localparam logic [SEQ_CNT_W-1:0] CNT_ONE    = SEQ_CNT_W'(1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE    = IDX_W'(1);

    seq_state_t            state_q, state_d;
    logic [SEQ_CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_CH-1:0]     ch_rst_q;
    logic [NUM_CH-1:0]     rel_vec;
    logic                  accept;
    logic                  div_rst;

    // Sequencer state, shared cycle counter and next-channel index
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SEQ_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state decode: hold timer, staged releases, soft-reset acceptance in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_vec = '0;
        accept  = 1'b0;
        case (state_q)
            SEQ_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    rel_vec[0] = 1'b1;
                    cnt_d      = '0;
                    idx_d      = IDX_ONE;
                    state_d    = (NUM_CH == 1) ? SEQ_RUN : SEQ_STAGE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SEQ_STAGE: begin
                if (cnt_q == STAGE_LAST) begin
                    rel_vec[idx_q] = 1'b1;
                    cnt_d          = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = SEQ_RUN;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SEQ_RUN: begin
`ifdef CLK_RESET_SEQ_SOFT_RST_EN
                if (SOFT_RST_REQ) begin
                    accept  = 1'b1;
                    state_d = SEQ_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
`endif
            end
            default: begin
                state_d = SEQ_HOLD;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Per-channel reset flops: drop on their release strobe, all reassert on RST or soft reset
    always_ff @(posedge CLK) begin
        if (RST || accept) begin
            ch_rst_q <= '1;
        end else begin
            ch_rst_q <= ch_rst_q & ~rel_vec;
        end
    end

`ifdef CLK_RESET_SEQ_SOFT_RST_EN
    logic ack_q;

    // Acknowledge pulse is registered on the accepting edge; RST drops any pending pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= accept;
        end
    end

    assign SOFT_RST_ACK = ack_q;
`else
    logic unused_soft_rst_req;
    assign unused_soft_rst_req = SOFT_RST_REQ;
    assign SOFT_RST_ACK        = 1'b0;
`endif

    assign div_rst   = RST || accept;
    assign CH_RST    = ch_rst_q;
    assign CH_RSTN   = ~ch_rst_q;
    assign ALL_READY = (state_q == SEQ_RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_ce_divider #(
            .CNT_W (CNT_W)
        ) u_div (
            .CLK      (CLK),
            .RST      (div_rst),
            .LOAD     (rel_vec[i]),
            .RELEASED (~ch_rst_q[i]),
            .RATIO    (DIV_RATIO[i*CNT_W +: CNT_W]),
            .PHASE    (PHASE[i*CNT_W +: CNT_W]),
            .CE       (CH_CE[i]),
            .TOGGLE   (CH_TOGGLE[i])
        );
    end

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// tb/tb_clk_reset_sequencer.sv - directed self-checking bench for clk_reset_sequencer
module tb_clk_reset_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] div_ratio = '0;
    logic [31:0] phase = '0;
    logic        soft_rst_req = 1'b0;
    logic        soft_rst_ack;
    logic [3:0]  ch_rst;
    logic [3:0]  ch_rstn;
    logic [3:0]  ch_ce;
    logic [3:0]  ch_toggle;
    logic        all_ready;

    int n_checks = 0;
    int n_fail   = 0;

    int r_eff[4];
    int p_eff[4];

    localparam logic [17:0] RESET_VEC  = 18'b0_0_1111_0000_0000_0000;
    localparam logic [17:0] ACCEPT_VEC = 18'b1_0_1111_0000_0000_0000;

    clk_reset_sequencer dut (
        .CLK          (clk),
        .RST          (rst),
        .DIV_RATIO    (div_ratio),
        .PHASE        (phase),
        .SOFT_RST_REQ (soft_rst_req),
        .SOFT_RST_ACK (soft_rst_ack),
        .CH_RST       (ch_rst),
        .CH_RSTN      (ch_rstn),
        .CH_CE        (ch_ce),
        .CH_TOGGLE    (ch_toggle),
        .ALL_READY    (all_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] observed();
        return {soft_rst_ack, all_ready, ch_rst, ch_rstn, ch_ce, ch_toggle};
    endfunction

    // Channel ch is released on edge 4 + 2*ch (edge 0 = first edge with RST low)
    function automatic int exp_ce(int ch, int e);
        int rel;
        rel = 4 + 2 * ch;
        if (e < rel) return 0;
        return (((p_eff[ch] + e - rel) % r_eff[ch]) == (r_eff[ch] - 1)) ? 1 : 0;
    endfunction

    function automatic int exp_tog(int ch, int e);
        int t;
        t = 0;
        for (int k = 4 + 2 * ch; k < e; k++) t ^= exp_ce(ch, k);
        return t;
    endfunction

    // Expected {ack, ready, rst, rstn, ce, toggle} after edge e
    function automatic logic [17:0] exp_outputs(int e);
        logic [3:0] r, c, t;
        for (int ch = 0; ch < 4; ch++) begin
            r[ch] = (e < 4 + 2 * ch);
            c[ch] = (exp_ce(ch, e) != 0);
            t[ch] = (exp_tog(ch, e) != 0);
        end
        return {1'b0, (e >= 10), r, ~r, c, t};
    endfunction

    task automatic cfg_ratio1();
        div_ratio = {8'd1, 8'd1, 8'd1, 8'd1};
        phase     = '0;
        for (int i = 0; i < 4; i++) begin
            r_eff[i] = 1;
            p_eff[i] = 0;
        end
    endtask

    // ch0 ratio 1; ch1 ratio 4 phase 0; ch2 ratio 5 phase 9 -> 4; ch3 ratio 0 -> 1
    task automatic cfg_mixed();
        div_ratio = {8'd0, 8'd5, 8'd4, 8'd1};
        phase     = {8'd0, 8'd9, 8'd0, 8'd0};
        r_eff = '{1, 4, 5, 1};
        p_eff = '{0, 0, 4, 0};
    endtask

    task automatic test_reset();
        cfg_ratio1();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (observed() !== RESET_VEC) begin
                n_fail++;
                $display("FAIL reset_values cycle=%0d got %b expected %b", c, observed(), RESET_VEC);
            end
        end
    endtask

    task automatic test_staged_release();
        rst = 1'b0;
        for (int e = 0; e < 16; e++) begin
            tick();
            n_checks++;
            if (observed() !== exp_outputs(e)) begin
                n_fail++;
                $display("FAIL staged_release edge=%0d got %b expected %b", e, observed(), exp_outputs(e));
            end
        end
    endtask

    task automatic test_dividers();
        rst = 1'b1;
        tick();
        tick();
        cfg_mixed();
        rst = 1'b0;
        for (int e = 0; e < 40; e++) begin
            tick();
            n_checks++;
            if (observed() !== exp_outputs(e)) begin
                n_fail++;
                $display("FAIL dividers edge=%0d got %b expected %b", e, observed(), exp_outputs(e));
            end
            if (e == 12) begin
                div_ratio = {8'd7, 8'd3, 8'd2, 8'd9};
                phase     = {8'd1, 8'd1, 8'd1, 8'd1};
            end
        end
    endtask

    task automatic test_rst_mid_stage();
        rst = 1'b1;
        tick();
        cfg_mixed();
        rst = 1'b0;
        for (int e = 0; e < 7; e++) begin
            tick();
            n_checks++;
            if (observed() !== exp_outputs(e)) begin
                n_fail++;
                $display("FAIL mid_stage_pre edge=%0d got %b expected %b", e, observed(), exp_outputs(e));
            end
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (observed() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL mid_stage_rst got %b expected %b", observed(), RESET_VEC);
        end
        tick();
        rst = 1'b0;
        for (int e = 0; e < 25; e++) begin
            tick();
            n_checks++;
            if (observed() !== exp_outputs(e)) begin
                n_fail++;
                $display("FAIL mid_stage_restart edge=%0d got %b expected %b", e, observed(), exp_outputs(e));
            end
        end
    endtask

    task automatic test_soft_reset();
        rst = 1'b1;
        tick();
        cfg_mixed();
        rst = 1'b0;
        for (int e = 0; e < 14; e++) begin
            tick();
            n_checks++;
            if (observed() !== exp_outputs(e)) begin
                n_fail++;
                $display("FAIL soft_pre edge=%0d got %b expected %b", e, observed(), exp_outputs(e));
            end
        end
        soft_rst_req = 1'b1;
`ifdef CLK_RESET_SEQ_SOFT_RST_EN
        tick();
        n_checks++;
        if (observed() !== ACCEPT_VEC) begin
            n_fail++;
            $display("FAIL soft_accept got %b expected %b", observed(), ACCEPT_VEC);
        end
        for (int e = 0; e < 25; e++) begin
            tick();
            n_checks++;
            if (observed() !== exp_outputs(e)) begin
                n_fail++;
                $display("FAIL soft_rerun edge=%0d got %b expected %b", e, observed(), exp_outputs(e));
            end
            if (e == 9) soft_rst_req = 1'b0;
        end
`else
        for (int e = 14; e < 26; e++) begin
            tick();
            n_checks++;
            if (observed() !== exp_outputs(e)) begin
                n_fail++;
                $display("FAIL soft_disabled edge=%0d got %b expected %b", e, observed(), exp_outputs(e));
            end
        end
        soft_rst_req = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_staged_release();
        test_dividers();
        test_rst_mid_stage();
        test_soft_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
